dot_arbiter: RTL

- Shares one dot unit between N_REQ requester stages, e.g. the ray-sphere and ray-plane pipelines. The dot unit has a FIFO-style input (empty/rd_en) and output (empty/rd_en).
- Round-robin arbitration on the issue side. Each granted requester ID is recorded in an in-order tag FIFO, and each dot result is routed back to the requester that issued it.
- Sits between the requesters' operand FIFOs and the dot instance, and between the dot result FIFO and the requesters' result FIFOs.

---
 rtl/dot_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dot_arbiter.sv
// Round-robin issue arbiter and in-order return router that shares one
// FIFO-style dot unit between N_REQ requester pipelines.
module dot_arbiter #(
  parameter int N_REQ     = 2,
  parameter int TAG_DEPTH = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [N_REQ-1:0][2:0][31:0]          req_x,
  input  logic [N_REQ-1:0][2:0][31:0]          req_y,
  input  logic [N_REQ-1:0]                     req_empty,
  output logic [N_REQ-1:0]                     req_rd_en,
  output logic [2:0][31:0]                     dot_x,
  output logic [2:0][31:0]                     dot_y,
  output logic                                 dot_in_empty,
  input  logic                                 dot_in_rd_en,
  input  logic [31:0]                          dot_out,
  input  logic                                 dot_out_empty,
  output logic                                 dot_out_rd_en,
  output logic [31:0]                          rsp_data,
  output logic [N_REQ-1:0]                     rsp_wr_en,
  input  logic [N_REQ-1:0]                     rsp_full,
  output logic [$clog2(TAG_DEPTH):0]           outstanding
);

  localparam int TW = $clog2(N_REQ);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {I_ARB, I_GRANT} istate_t;
  typedef enum logic {R_IDLE, R_WRITE} rstate_t;

  istate_t         r_ist, w_ist_nxt;
  rstate_t         r_rst, w_rst_nxt;
  logic [TW-1:0]   r_rr_ptr;
  logic [TW-1:0]   r_grant;
  logic [TW-1:0]   r_tag_mem [TAG_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic            w_found;
  logic [TW-1:0]   w_pick;
  int              w_best;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [TW-1:0]   w_head;
  logic            w_ret_ok;

  assign w_full  = (r_count == CW'(TAG_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = (r_ist == I_GRANT) && dot_in_rd_en;
  assign w_pop   = (r_rst == R_WRITE);
  assign w_head  = r_tag_mem[r_rptr];
  assign outstanding = r_count;

  // Smallest rotational distance from rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_best  = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (!req_empty[i] &&
          ((i + N_REQ - int'(r_rr_ptr)) % N_REQ) < w_best) begin
        w_found = 1'b1;
        w_pick  = TW'(i);
        w_best  = (i + N_REQ - int'(r_rr_ptr)) % N_REQ;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ist <= I_ARB;
    end else begin
      r_ist <= w_ist_nxt;
    end
  end

  always_comb begin
    w_ist_nxt = r_ist;
    unique case (r_ist)
      I_ARB:   if (w_found && !w_full) w_ist_nxt = I_GRANT;
      I_GRANT: if (dot_in_rd_en) w_ist_nxt = I_ARB;
      default: w_ist_nxt = I_ARB;
    endcase
  end

  always_comb begin
    req_rd_en    = '0;
    dot_in_empty = 1'b1;
    if (r_ist == I_GRANT) begin
      dot_in_empty       = 1'b0;
      req_rd_en[r_grant] = dot_in_rd_en;
    end
  end

  assign dot_x = req_x[r_grant];
  assign dot_y = req_y[r_grant];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (r_ist == I_ARB && w_found && !w_full) begin
        r_grant <= w_pick;
      end
      if (w_push) begin
        r_rr_ptr <= (r_grant == TW'(N_REQ - 1)) ? '0 : r_grant + TW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_tag_mem[r_wptr] <= r_grant;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head-of-line: a full destination stalls every later return.
  assign w_ret_ok = !dot_out_empty && !w_empty && !rsp_full[w_head];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rst <= R_IDLE;
    end else begin
      r_rst <= w_rst_nxt;
    end
  end

  always_comb begin
    w_rst_nxt = r_rst;
    unique case (r_rst)
      R_IDLE:  if (w_ret_ok) w_rst_nxt = R_WRITE;
      R_WRITE: w_rst_nxt = R_IDLE;
      default: w_rst_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    dot_out_rd_en = 1'b0;
    rsp_data      = '0;
    rsp_wr_en     = '0;
    unique case (r_rst)
      R_IDLE: dot_out_rd_en = w_ret_ok;
      R_WRITE: begin
        rsp_data          = dot_out;
        rsp_wr_en[w_head] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
